// File: rtl/dbg_req_demux_pkg.sv
// Shared types and constants for the debug request demultiplexer.
package dbg_req_demux_pkg;

  localparam int unsigned DBG_DATA_W = 32;

  // Transaction states; the top uses 2-bit localparam aliases of these.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Request fields latched at accept time and replayed to the target.
  typedef struct packed {
    logic [DBG_DATA_W-1:0] addr;
    logic [DBG_DATA_W-1:0] wdata;
    logic                  we;
  } dbg_req_t;

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Transaction timeout counter for dbg_req_demux.
// Only built with DBG_REQ_DEMUX_TIMEOUT_EN defined (its only user is guarded the same way).
`ifdef DBG_REQ_DEMUX_TIMEOUT_EN
module dbg_timeout_cnt #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  // Count cycles spent in the outstanding phase; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires in the cycle whose closing edge brings the count to LIMIT.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/dbg_req_demux.sv
// Debug request demultiplexer: routes one debugger request to the CSR port
// (target 0) or the data memory port (target 1) by address bit SEL_BIT and
// returns that target's response as a one-cycle pulse.
// Optional: DBG_REQ_DEMUX_TIMEOUT_EN adds an error response after
// TIMEOUT_CYCLES cycles outstanding; without it the block waits forever.
module dbg_req_demux
  import dbg_req_demux_pkg::*;
#(
  parameter int unsigned SEL_BIT        = 28,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DBG_DATA_W-1:0] req_addr,
  input  logic [DBG_DATA_W-1:0] req_wdata,
  input  logic                  req_we,
  output logic                  rsp_valid,
  output logic [DBG_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  t0_valid,
  input  logic                  t0_ready,
  output logic [DBG_DATA_W-1:0] t0_addr,
  output logic [DBG_DATA_W-1:0] t0_wdata,
  output logic                  t0_we,
  input  logic                  t0_rvalid,
  input  logic [DBG_DATA_W-1:0] t0_rdata,
  output logic                  t1_valid,
  input  logic                  t1_ready,
  output logic [DBG_DATA_W-1:0] t1_addr,
  output logic [DBG_DATA_W-1:0] t1_wdata,
  output logic                  t1_we,
  input  logic                  t1_rvalid,
  input  logic [DBG_DATA_W-1:0] t1_rdata
);

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] ISSUE = 2'(ST_ISSUE);
  localparam logic [1:0] WAIT  = 2'(ST_WAIT);
  localparam logic [1:0] RESP  = 2'(ST_RESP);

  logic [1:0]            state_q;
  logic [1:0]            state_nxt;
  dbg_req_t              req_q;
  logic                  sel_q;
  logic                  accept_c;
  logic                  handshake_c;
  logic                  resp_cap_c;
  logic                  timeout_c;
  logic                  sel_ready_c;
  logic                  sel_rvalid_c;
  logic [DBG_DATA_W-1:0] sel_rdata_c;

  // Only the selected target's handshake and response are ever observed.
  assign sel_ready_c  = sel_q ? t1_ready  : t0_ready;
  assign sel_rvalid_c = sel_q ? t1_rvalid : t0_rvalid;
  assign sel_rdata_c  = sel_q ? t1_rdata  : t0_rdata;

  // Ready is a state decode gated by reset so it is low while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Both targets see the latched fields; only the selected one gets valid.
  assign t0_addr  = req_q.addr;
  assign t0_wdata = req_q.wdata;
  assign t0_we    = req_q.we;
  assign t1_addr  = req_q.addr;
  assign t1_wdata = req_q.wdata;
  assign t1_we    = req_q.we;

`ifdef DBG_REQ_DEMUX_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_count_unused;
  logic             tmo_en_c;

  assign tmo_en_c = (state_q == ISSUE) || (state_q == WAIT);

  dbg_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_c),
    .enable  (tmo_en_c),
    .count   (tmo_count_unused),
    .expired (timeout_c)
  );

  // Error flag: set by a timeout, cleared by a real response, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (timeout_c) begin
      rsp_err <= 1'b1;
    end else if (resp_cap_c) begin
      rsp_err <= 1'b0;
    end
  end
`else
  logic [CNT_W-1:0] cfg_unused;

  assign cfg_unused = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_c  = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and transfer strobes; a timeout overrides ready/rvalid.
  always_comb begin
    state_nxt   = state_q;
    accept_c    = 1'b0;
    handshake_c = 1'b0;
    resp_cap_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_c) begin
          state_nxt = RESP;
        end else if (sel_ready_c) begin
          handshake_c = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (timeout_c) begin
          state_nxt = RESP;
        end else if (sel_rvalid_c) begin
          resp_cap_c = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, target valids and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      sel_q     <= 1'b0;
      t0_valid  <= 1'b0;
      t1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      if (accept_c) begin
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        req_q.we    <= req_we;
        sel_q       <= req_addr[SEL_BIT];
        t0_valid    <= ~req_addr[SEL_BIT];
        t1_valid    <= req_addr[SEL_BIT];
      end else if (handshake_c || timeout_c) begin
        t0_valid <= 1'b0;
        t1_valid <= 1'b0;
      end
      if (resp_cap_c) begin
        rsp_rdata <= req_q.we ? '0 : sel_rdata_c;
      end else if (timeout_c) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dbg_req_demux.sv
// Directed testbench for dbg_req_demux. Build with DBG_REQ_DEMUX_TIMEOUT_EN
// defined to exercise the timeout path (TIMEOUT_CYCLES=8 here).
module tb_dbg_req_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        t0_valid, t0_ready, t0_we, t0_rvalid;
  logic [31:0] t0_addr, t0_wdata, t0_rdata;
  logic        t1_valid, t1_ready, t1_we, t1_rvalid;
  logic [31:0] t1_addr, t1_wdata, t1_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dbg_req_demux #(
    .SEL_BIT        (28),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .t0_valid  (t0_valid),
    .t0_ready  (t0_ready),
    .t0_addr   (t0_addr),
    .t0_wdata  (t0_wdata),
    .t0_we     (t0_we),
    .t0_rvalid (t0_rvalid),
    .t0_rdata  (t0_rdata),
    .t1_valid  (t1_valid),
    .t1_ready  (t1_ready),
    .t1_addr   (t1_addr),
    .t1_wdata  (t1_wdata),
    .t1_we     (t1_we),
    .t1_rvalid (t1_rvalid),
    .t1_rdata  (t1_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    t0_ready = 1'b0; t0_rvalid = 1'b0; t0_rdata = '0;
    t1_ready = 1'b0; t1_rvalid = 1'b0; t1_rdata = '0;

    // Reset state
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_t0_valid", t0_valid, 0);
    chk("rst_t1_valid", t1_valid, 0);
    chk("rst_t0_addr", t0_addr, 0);
    chk("rst_t1_wdata", t1_wdata, 0);
    #9; rst_n = 1'b1; #1;
    chk("rel_req_ready", req_ready, 1);

    // Read target 0, best-case latency
    req_valid = 1'b1; req_addr = 32'h0000_0010; req_we = 1'b0;
    step();
    chk("rd0_t0_valid", t0_valid, 1);
    chk("rd0_t1_valid", t1_valid, 0);
    chk("rd0_t0_addr", t0_addr, 32'h0000_0010);
    chk("rd0_t0_we", t0_we, 0);
    chk("rd0_req_ready", req_ready, 0);
    chk("rd0_busy", busy, 1);
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    chk("rd0_wait_t0_valid", t0_valid, 0);
    chk("rd0_wait_rsp_valid", rsp_valid, 0);
    t0_ready = 1'b0; t0_rvalid = 1'b1; t0_rdata = 32'hCAFE_0001;
    step();
    chk("rd0_rsp_valid", rsp_valid, 1);
    chk("rd0_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    chk("rd0_rsp_err", rsp_err, 0);
    chk("rd0_t1_valid_end", t1_valid, 0);
    t0_rvalid = 1'b0;
    step();
    chk("rd0_rsp_pulse", rsp_valid, 0);
    chk("rd0_idle_ready", req_ready, 1);
    chk("rd0_idle_busy", busy, 0);
    chk("rd0_rdata_hold", rsp_rdata, 32'hCAFE_0001);

    // Write target 1 with ready delayed three cycles
    req_valid = 1'b1; req_addr = 32'h1000_0040; req_wdata = 32'h1234_5678; req_we = 1'b1;
    step();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr1_t1_valid", t1_valid, 1);
      chk("wr1_t0_valid", t0_valid, 0);
      chk("wr1_t1_addr", t1_addr, 32'h1000_0040);
      chk("wr1_t1_wdata", t1_wdata, 32'h1234_5678);
      chk("wr1_t1_we", t1_we, 1);
      if (i == 3) t1_ready = 1'b1;
      step();
    end
    chk("wr1_t0_addr_shadow", t0_addr, 32'h1000_0040);
    chk("wr1_wait_t1_valid", t1_valid, 0);
    t1_ready = 1'b0; t1_rvalid = 1'b1; t1_rdata = 32'hFFFF_FFFF;
    step();
    chk("wr1_rsp_valid", rsp_valid, 1);
    chk("wr1_rsp_rdata", rsp_rdata, 0);
    chk("wr1_rsp_err", rsp_err, 0);
    t1_rvalid = 1'b0;
    step();
    chk("wr1_idle", busy, 0);

    // Stray target 1 response and ready+rvalid together during a target 0 read
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_we = 1'b0;
    step();
    req_valid = 1'b0;
    t0_ready = 1'b1; t0_rvalid = 1'b1; t0_rdata = 32'h0000_0055;
    t1_rvalid = 1'b1; t1_rdata = 32'hBAD0_BAD0;
    step();
    chk("str_no_rsp_same_cycle", rsp_valid, 0);
    chk("str_t0_valid_drop", t0_valid, 0);
    t0_ready = 1'b0; t0_rvalid = 1'b0;
    step();
    chk("str_ignored_rsp", rsp_valid, 0);
    chk("str_busy", busy, 1);
    t1_rvalid = 1'b0; t0_rvalid = 1'b1; t0_rdata = 32'h0000_00AA;
    step();
    chk("str_rsp_valid", rsp_valid, 1);
    chk("str_rsp_rdata", rsp_rdata, 32'h0000_00AA);
    t0_rvalid = 1'b0;
    step();

    // Back-to-back requests with req_valid held high
    req_valid = 1'b1; req_addr = 32'h1000_0000; req_we = 1'b0;
    step();
    chk("b2b_a_t1_valid", t1_valid, 1);
    chk("b2b_a_ready_issue", req_ready, 0);
    t1_ready = 1'b1;
    step();
    chk("b2b_a_ready_wait", req_ready, 0);
    t1_ready = 1'b0; t1_rvalid = 1'b1; t1_rdata = 32'h0000_0011;
    step();
    chk("b2b_a_rsp_valid", rsp_valid, 1);
    chk("b2b_a_rsp_rdata", rsp_rdata, 32'h0000_0011);
    chk("b2b_a_ready_resp", req_ready, 0);
    t1_rvalid = 1'b0; req_addr = 32'h0000_0004;
    step();
    chk("b2b_gap_ready", req_ready, 1);
    chk("b2b_gap_t0_valid", t0_valid, 0);
    chk("b2b_gap_rsp_valid", rsp_valid, 0);
    step();
    chk("b2b_b_t0_valid", t0_valid, 1);
    chk("b2b_b_t0_addr", t0_addr, 32'h0000_0004);
    chk("b2b_b_ready", req_ready, 0);
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0; t0_rvalid = 1'b1; t0_rdata = 32'h0000_0022;
    step();
    chk("b2b_b_rsp_rdata", rsp_rdata, 32'h0000_0022);
    t0_rvalid = 1'b0;
    step();

    // Target 1 never ready
    req_valid = 1'b1; req_addr = 32'h1000_0100; req_we = 1'b0;
    step();
    req_valid = 1'b0;
`ifdef DBG_REQ_DEMUX_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      chk("tmo_pending_valid", t1_valid, 1);
      chk("tmo_pending_rsp", rsp_valid, 0);
    end
    step();
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    chk("tmo_t1_valid", t1_valid, 0);
    t1_rvalid = 1'b1; t1_rdata = 32'h0000_0077;
    step();
    chk("tmo_stray_rsp", rsp_valid, 0);
    chk("tmo_idle", busy, 0);
    t1_rvalid = 1'b0;
    step();
    chk("tmo_stray_rdata", rsp_rdata, 0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("nto_busy", busy, 1);
    chk("nto_t1_valid", t1_valid, 1);
    chk("nto_rsp_valid", rsp_valid, 0);
    t1_ready = 1'b1;
    step();
    t1_ready = 1'b0; t1_rvalid = 1'b1; t1_rdata = 32'h0000_0033;
    step();
    chk("nto_rsp_rdata", rsp_rdata, 32'h0000_0033);
    chk("nto_rsp_err", rsp_err, 0);
    t1_rvalid = 1'b0;
    step();
`endif

    // Reset in WAIT aborts without a response
    req_valid = 1'b1; req_addr = 32'h0000_0008; req_we = 1'b0;
    step();
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    chk("mrst_pre_busy", busy, 1);
    #2; rst_n = 1'b0; t0_rvalid = 1'b1; t0_rdata = 32'h0000_0099;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_t0_valid", t0_valid, 0);
    chk("mrst_req_ready", req_ready, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    step();
    t0_rvalid = 1'b0;
    #2; rst_n = 1'b1; #1;
    chk("mrst_rel_ready", req_ready, 1);
    chk("mrst_rel_rsp_valid", rsp_valid, 0);
    step();
    chk("mrst_no_rsp", rsp_valid, 0);
    chk("mrst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
